// File: rtl/dmac_buffer_pkg.sv
// Shared definitions for the DMAC buffer credit allocator.
//   dmac_credit_state_e : allocator FSM states
//   ERR_*               : bit positions inside the sticky err vector
package dmac_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } dmac_credit_state_e;

    localparam int ERR_OVERFLOW   = 0;  // credit overflow or burst_done with nothing in flight
    localparam int ERR_BAD_LEN    = 1;  // request length 0 or above MAX_BURST
    localparam int ERR_LEN_CHANGE = 2;  // req_len moved while a request was pending
    localparam int ERR_W          = 3;

endpackage

// File: rtl/dmac_sat_ctr.sv
// Saturating up-counter.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears count
//   inc   : add one this cycle (ignored once count is all ones)
//   count : current value
module dmac_sat_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/dmac_buffer_credit_alloc.sv
// Producer-side free-space tracker for a DMAC data buffer. A burst request is
// granted only when the buffer can take the whole burst and fewer than
// MAX_OUTSTANDING bursts are in flight. Consumer releases return credits.
// A level drain_req stops granting and pulses drain_done once idle.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_len   : burst reservation request (length in elements)
//   req_ready           : grant, combinational on registered state and req_len
//   rel/rel_count       : consumer released rel_count elements
//   burst_done          : one granted burst has landed
//   drain_req/drain_done: teardown handshake (done is a 1-cycle pulse)
//   free, outstanding   : registered credit and in-flight counts
//   stall_cycles        : saturating count of req_valid & !req_ready cycles
//   err                 : sticky error flags, see ERR_* in dmac_buffer_pkg
module dmac_buffer_credit_alloc
    import dmac_buffer_pkg::*;
#(
    parameter int MAX_ELEMENTS    = 16,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW = $clog2(MAX_ELEMENTS + 1),
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic [CW-1:0] req_len,
    output logic          req_ready,
    input  logic          rel,
    input  logic [CW-1:0] rel_count,
    input  logic          burst_done,
    input  logic          drain_req,
    output logic          drain_done,
    output logic [CW-1:0] free,
    output logic [OW-1:0] outstanding,
    output logic [15:0]   stall_cycles,
    output logic [2:0]    err
);

    dmac_credit_state_e state_reg;
    logic [CW-1:0]      free_reg, free_next;
    logic [OW-1:0]      outstanding_reg, outstanding_next;
    logic [CW-1:0]      len_cap_reg;
    logic               drain_done_reg;
    logic [ERR_W-1:0]   err_reg, err_set;

    logic               bad_len, fire, legal_fire;
    logic               ost_inc, ost_dec, spurious_done;
    logic               overflow, quiescent;
    logic [CW:0]        free_sum;

    assign bad_len    = (req_len == '0) || (req_len > CW'(MAX_BURST));
    assign req_ready  = (state_reg != ST_DRAIN)
                      && (outstanding_reg < OW'(MAX_OUTSTANDING))
                      && (bad_len || (req_len <= free_reg));
    assign fire       = req_valid && req_ready;
    // Bad-length requests are acknowledged so the requester cannot hang,
    // but they reserve nothing and do not count as in flight.
    assign legal_fire = fire && !bad_len;

    // One extra bit so an over-release is seen instead of wrapping. A legal
    // fire never exceeds free, so the subtraction cannot underflow.
    assign free_sum = {1'b0, free_reg}
                    - (legal_fire ? {1'b0, req_len} : {(CW+1){1'b0}})
                    + (rel ? {1'b0, rel_count} : {(CW+1){1'b0}});
    assign overflow  = free_sum > (CW+1)'(MAX_ELEMENTS);
    assign free_next = overflow ? CW'(MAX_ELEMENTS) : free_sum[CW-1:0];

    assign ost_inc       = legal_fire;
    assign spurious_done = burst_done && (outstanding_reg == '0);
    assign ost_dec       = burst_done && !spurious_done;

    always_comb begin
        outstanding_next = outstanding_reg;
        if (ost_inc && !ost_dec) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!ost_inc && ost_dec) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    // Drain completes only when nothing is in flight and no credit
    // movement is happening in the same cycle.
    assign quiescent = (free_reg == CW'(MAX_ELEMENTS)) && (outstanding_reg == '0)
                     && !rel && !burst_done;

    always_comb begin
        err_set                 = '0;
        err_set[ERR_OVERFLOW]   = overflow || spurious_done;
        err_set[ERR_BAD_LEN]    = fire && bad_len;
        err_set[ERR_LEN_CHANGE] = (state_reg == ST_WAIT) && (req_len != len_cap_reg);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_reg        <= CW'(MAX_ELEMENTS);
            outstanding_reg <= '0;
        end else begin
            free_reg        <= free_next;
            outstanding_reg <= outstanding_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ERR_W; gi++) begin : g_err
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    err_reg[gi] <= 1'b0;
                end else if (err_set[gi]) begin
                    err_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            len_cap_reg    <= '0;
            drain_done_reg <= 1'b0;
        end else begin
            drain_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (drain_req) begin
                        state_reg <= ST_DRAIN;
                    end else if (req_valid && !req_ready) begin
                        state_reg   <= ST_WAIT;
                        len_cap_reg <= req_len;
                    end
                end
                ST_WAIT: begin
                    if (drain_req) begin
                        state_reg <= ST_DRAIN;
                    end else if (fire) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (quiescent) begin
                        drain_done_reg <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end else if (!drain_req) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    dmac_sat_ctr #(.W(16)) u_stall_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (req_valid && !req_ready),
        .count (stall_cycles)
    );

    assign free        = free_reg;
    assign outstanding = outstanding_reg;
    assign drain_done  = drain_done_reg;
    assign err         = err_reg;

endmodule
